integer_execute: RTL

Single-lane integer execute stage on the issue side of the integer issue queue. Consumes the queue's issue handshake (issue valid, ROB id, registered issue data) and computes ALU, U-type and jump/branch results. Drives the ALU broadcast bus back into the issue queue for wakeup, capture and bypass. Registers a ROB completion record and a fetch redirect on branch/jump resolution.

---
 rtl/integer_execute.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/integer_execute.sv
// Single-lane integer execute stage: ALU/U-type/jump/branch, broadcast, ROB completion, redirect.
// Optional branch statistics counters built only when IEX_BR_STATS_EN is defined.
module integer_execute #(
  parameter int XLEN                 = 32,
  parameter int ROB_ID_WIDTH         = 6,
  parameter int IIQ_ISSUE_DATA_WIDTH = 4*XLEN + 13
) (
  input  logic                            clk,
  input  logic                            init,
  input  logic                            rst_aL,
  input  logic                            issue_valid,
  input  logic [ROB_ID_WIDTH-1:0]         issue_rob_id,
  input  logic [IIQ_ISSUE_DATA_WIDTH-1:0] issue_data,
  input  logic                            fetch_redirect_valid,
  output logic                            alu_broadcast_valid,
  output logic [ROB_ID_WIDTH-1:0]         alu_broadcast_rob_id,
  output logic [XLEN-1:0]                 alu_broadcast_reg_data,
  output logic                            rob_complete_valid,
  output logic [ROB_ID_WIDTH-1:0]         rob_complete_rob_id,
  output logic                            rob_complete_mispred,
  output logic                            iex_redirect_valid,
  output logic [XLEN-1:0]                 iex_redirect_pc,
  output logic [31:0]                     br_count,
  output logic [31:0]                     br_mispred_count
);

  typedef logic [XLEN-1:0] reg_data_t;

  // Decode classes are one-hot; an all-zero class yields a zero result.
  typedef struct packed {
    reg_data_t  pc;
    reg_data_t  imm;
    reg_data_t  src1_data;
    reg_data_t  src2_data;
    logic [2:0] funct3;
    logic       is_r_type;
    logic       is_i_type;
    logic       is_lui;
    logic       is_auipc;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic       is_sub;
    logic       is_sra_srai;
    logic       br_dir_pred;
  } iiq_issue_data_t;

  iiq_issue_data_t id;
  assign id = iiq_issue_data_t'(issue_data);

  logic                    ex_valid_q, ex_valid_d;
  logic [ROB_ID_WIDTH-1:0] ex_rob_id_q, ex_rob_id_d;
  logic                    rc_valid_q, rc_valid_d;
  logic [ROB_ID_WIDTH-1:0] rc_rob_id_q, rc_rob_id_d;
  logic                    rc_mispred_q, rc_mispred_d;
  logic                    redir_valid_q, redir_valid_d;
  reg_data_t               redir_pc_q, redir_pc_d;

  reg_data_t               opb, alu_res, result, pc_plus4, pc_plus_imm, jalr_tgt, next_pc;
  logic signed [XLEN-1:0]  src1_s, src2_s, opb_s;
  logic [4:0]              shamt;
  logic                    br_taken, taken, mispred, bcast;

  always_comb begin
    opb         = id.is_r_type ? id.src2_data : id.imm;
    src1_s      = id.src1_data;
    src2_s      = id.src2_data;
    opb_s       = opb;
    shamt       = opb[4:0];
    pc_plus4    = id.pc + reg_data_t'(4);
    pc_plus_imm = id.pc + id.imm;
    jalr_tgt    = (id.src1_data + id.imm) & ~reg_data_t'(1);

    unique case (id.funct3)
      3'b000:  alu_res = (id.is_r_type && id.is_sub) ? id.src1_data - opb : id.src1_data + opb;
      3'b001:  alu_res = id.src1_data << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, src1_s < opb_s};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, id.src1_data < opb};
      3'b100:  alu_res = id.src1_data ^ opb;
      3'b101:  alu_res = id.is_sra_srai ? reg_data_t'(src1_s >>> shamt) : id.src1_data >> shamt;
      3'b110:  alu_res = id.src1_data | opb;
      default: alu_res = id.src1_data & opb;
    endcase

    unique case (id.funct3)
      3'b000:  br_taken = id.src1_data == id.src2_data;
      3'b001:  br_taken = id.src1_data != id.src2_data;
      3'b100:  br_taken = src1_s < src2_s;
      3'b101:  br_taken = src1_s >= src2_s;
      3'b110:  br_taken = id.src1_data < id.src2_data;
      3'b111:  br_taken = id.src1_data >= id.src2_data;
      default: br_taken = 1'b0;
    endcase

    if (id.is_lui)                      result = id.imm;
    else if (id.is_auipc)               result = pc_plus_imm;
    else if (id.is_jal || id.is_jalr)   result = pc_plus4;
    else if (id.is_r_type || id.is_i_type) result = alu_res;
    else                                result = '0;

    taken   = (id.is_branch & br_taken) | id.is_jal | id.is_jalr;
    // jalr has no target prediction upstream, so it always redirects.
    mispred = (id.is_branch & (br_taken != id.br_dir_pred)) | id.is_jalr;
    next_pc = taken ? (id.is_jalr ? jalr_tgt : pc_plus_imm) : pc_plus4;
  end

  // E1: broadcast is squashed by a global flush or by our own redirect (younger op).
  assign bcast                  = ex_valid_q & ~fetch_redirect_valid & ~redir_valid_q;
  assign alu_broadcast_valid    = bcast;
  assign alu_broadcast_rob_id   = ex_rob_id_q;
  assign alu_broadcast_reg_data = ex_valid_q ? result : '0;

  always_comb begin
    ex_valid_d    = issue_valid & ~fetch_redirect_valid & ~redir_valid_q;
    ex_rob_id_d   = ex_valid_d ? issue_rob_id : '0;
    rc_valid_d    = bcast;
    rc_rob_id_d   = bcast ? ex_rob_id_q : '0;
    rc_mispred_d  = bcast & mispred;
    redir_valid_d = bcast & mispred;
    redir_pc_d    = bcast ? next_pc : '0;
    if (init) begin
      ex_valid_d    = 1'b0;
      ex_rob_id_d   = '0;
      rc_valid_d    = 1'b0;
      rc_rob_id_d   = '0;
      rc_mispred_d  = 1'b0;
      redir_valid_d = 1'b0;
      redir_pc_d    = '0;
    end
  end

  // E2: completion record and redirect request.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      ex_valid_q    <= 1'b0;
      ex_rob_id_q   <= '0;
      rc_valid_q    <= 1'b0;
      rc_rob_id_q   <= '0;
      rc_mispred_q  <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rob_id_q   <= ex_rob_id_d;
      rc_valid_q    <= rc_valid_d;
      rc_rob_id_q   <= rc_rob_id_d;
      rc_mispred_q  <= rc_mispred_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign rob_complete_valid   = rc_valid_q;
  assign rob_complete_rob_id  = rc_rob_id_q;
  assign rob_complete_mispred = rc_mispred_q;
  assign iex_redirect_valid   = redir_valid_q;
  assign iex_redirect_pc      = redir_pc_q;

`ifdef IEX_BR_STATS_EN
  logic [31:0] br_count_q, br_count_d, br_mis_q, br_mis_d;

  always_comb begin
    br_count_d = br_count_q + 32'(bcast & (id.is_branch | id.is_jalr));
    br_mis_d   = br_mis_q + 32'(bcast & mispred);
    if (init) begin
      br_count_d = '0;
      br_mis_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      br_count_q <= '0;
      br_mis_q   <= '0;
    end else begin
      br_count_q <= br_count_d;
      br_mis_q   <= br_mis_d;
    end
  end

  assign br_count         = br_count_q;
  assign br_mispred_count = br_mis_q;
`else
  assign br_count         = '0;
  assign br_mispred_count = '0;
`endif

endmodule
